// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage pipelined core.
//
// Captures the decoded instruction (both register operands, immediate and control
// bundle) on each rising clock edge. Each operand has register 0 forced to zero and
// picks up a register written back in the same cycle. A load in EX whose destination
// matches either source of the instruction in ID causes a load-use hazard: stall is
// raised for one cycle and a bubble enters EX. A taken branch (flush) also forces a
// bubble.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   id_*                  instruction presented by decode / register file
//   wb_we/wb_addr/wb_data write-back port, used for same-cycle bypass
//   flush                 kill the instruction entering EX
//   stall                 combinational; hold PC and IF/ID this cycle
//   ex_*                  registered instruction for the EX stage
//   stall_count           saturating count of stall cycles
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CTRL_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [ADDR_W-1:0] ex_rs,
    output logic [ADDR_W-1:0] ex_rt,
    output logic [ADDR_W-1:0] ex_dst,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       stall_count
);

    localparam int unsigned CtrlMemRead = 1;
    localparam int unsigned CtrlRegDst  = 5;

    logic              ex_valid_q, ex_valid_d;
    logic [ADDR_W-1:0] ex_rs_q, ex_rs_d;
    logic [ADDR_W-1:0] ex_rt_q, ex_rt_d;
    logic [ADDR_W-1:0] ex_dst_q, ex_dst_d;
    logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [31:0]       stall_count_q, stall_count_d;
    logic              capture;

    // Zero register wins over bypass, so a write-back to r0 never leaks through.
    function automatic logic [DATA_W-1:0] sel_operand(input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] rf_data,
                                                      input logic              we,
                                                      input logic [ADDR_W-1:0] waddr,
                                                      input logic [DATA_W-1:0] wdata);
        if (addr == '0) begin
            return '0;
        end else if (we && (waddr == addr)) begin
            return wdata;
        end else begin
            return rf_data;
        end
    endfunction

    always_comb begin
        // Both sources are compared even if the instruction only reads rs.
        stall = id_valid & ex_valid_q & ex_ctrl_q[CtrlMemRead] & (ex_dst_q != '0) &
                ((ex_dst_q == id_rs) | (ex_dst_q == id_rt));

        capture = !flush && !stall && id_valid;

        ex_valid_d   = 1'b0;
        ex_rs_d      = '0;
        ex_rt_d      = '0;
        ex_dst_d     = '0;
        ex_rs_data_d = '0;
        ex_rt_data_d = '0;
        ex_imm_d     = '0;
        ex_ctrl_d    = '0;
        if (capture) begin
            ex_valid_d   = 1'b1;
            ex_rs_d      = id_rs;
            ex_rt_d      = id_rt;
            ex_dst_d     = id_ctrl[CtrlRegDst] ? id_rd : id_rt;
            ex_rs_data_d = sel_operand(id_rs, id_rs_data, wb_we, wb_addr, wb_data);
            ex_rt_data_d = sel_operand(id_rt, id_rt_data, wb_we, wb_addr, wb_data);
            ex_imm_d     = id_imm;
            ex_ctrl_d    = id_ctrl;
        end

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q    <= 1'b0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_dst_q      <= '0;
            ex_rs_data_q  <= '0;
            ex_rt_data_q  <= '0;
            ex_imm_q      <= '0;
            ex_ctrl_q     <= '0;
            stall_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            ex_dst_q      <= ex_dst_d;
            ex_rs_data_q  <= ex_rs_data_d;
            ex_rt_data_q  <= ex_rt_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_ctrl_q     <= ex_ctrl_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_dst      = ex_dst_q;
    assign ex_rs_data  = ex_rs_data_q;
    assign ex_rt_data  = ex_rt_data_q;
    assign ex_imm      = ex_imm_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a vector table for single-cycle capture
// behaviour plus hand-written load-use, flush, saturation and reset sequences.
// Expected EX contents are queued when stimulus is driven and popped after the edge.
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [9:0]  id_ctrl;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        stall;
    logic        ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [9:0]  ex_ctrl;
    logic [31:0] stall_count;

    id_ex_stage #(
        .DATA_W(32),
        .ADDR_W(5),
        .CTRL_W(10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_rs_data (id_rs_data),
        .id_rt_data (id_rt_data),
        .id_imm     (id_imm),
        .id_ctrl    (id_ctrl),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_dst     (ex_dst),
        .ex_rs_data (ex_rs_data),
        .ex_rt_data (ex_rt_data),
        .ex_imm     (ex_imm),
        .ex_ctrl    (ex_ctrl),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs followed by expected EX contents (rs/rt/imm follow the inputs on capture).
    typedef struct {
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [9:0]  ctrl;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        fl;
        logic        ev;
        logic [31:0] ers, ert;
        logic [4:0]  edst;
        logic [9:0]  ectrl;
    } vec_t;

    typedef struct {
        logic        ev;
        logic [4:0]  rs, rt, dst;
        logic [31:0] rsd, rtd, imm;
        logic [9:0]  ctrl;
        logic [31:0] cnt;
    } exp_t;

    vec_t        vecs[10];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid   = t.v;
        id_rs      = t.rs;
        id_rt      = t.rt;
        id_rd      = t.rd;
        id_rs_data = t.rsd;
        id_rt_data = t.rtd;
        id_imm     = t.imm;
        id_ctrl    = t.ctrl;
        wb_we      = t.we;
        wb_addr    = t.wa;
        wb_data    = t.wd;
        flush      = t.fl;
    endtask

    // Expected EX contents for an instruction given the bench's own decision to capture.
    task automatic push_exp(input vec_t t, input logic cap);
        exp_t e;
        e.ev   = cap;
        e.rs   = cap ? t.rs : 5'd0;
        e.rt   = cap ? t.rt : 5'd0;
        e.dst  = cap ? t.edst : 5'd0;
        e.rsd  = cap ? t.ers : 32'd0;
        e.rtd  = cap ? t.ert : 32'd0;
        e.imm  = cap ? t.imm : 32'd0;
        e.ctrl = cap ? t.ectrl : 10'd0;
        e.cnt  = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty: got 0 entries expected 1", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, ".ex_valid"},    32'(ex_valid),   32'(e.ev));
        check({tag, ".ex_rs"},       32'(ex_rs),      32'(e.rs));
        check({tag, ".ex_rt"},       32'(ex_rt),      32'(e.rt));
        check({tag, ".ex_dst"},      32'(ex_dst),     32'(e.dst));
        check({tag, ".ex_rs_data"},  ex_rs_data,      e.rsd);
        check({tag, ".ex_rt_data"},  ex_rt_data,      e.rtd);
        check({tag, ".ex_imm"},      ex_imm,          e.imm);
        check({tag, ".ex_ctrl"},     32'(ex_ctrl),    32'(e.ctrl));
        check({tag, ".stall_count"}, stall_count,     e.cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ex_valid"},    32'(ex_valid), 0);
        check({tag, ".ex_dst"},      32'(ex_dst),   0);
        check({tag, ".ex_rs_data"},  ex_rs_data,    0);
        check({tag, ".ex_rt_data"},  ex_rt_data,    0);
        check({tag, ".ex_imm"},      ex_imm,        0);
        check({tag, ".ex_ctrl"},     32'(ex_ctrl),  0);
        check({tag, ".ex_rs"},       32'(ex_rs),    0);
        check({tag, ".ex_rt"},       32'(ex_rt),    0);
        check({tag, ".stall_count"}, stall_count,   0);
        check({tag, ".stall"},       32'(stall),    0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t lw, dep;

        //          v  rs rt rd rsd          rtd          imm           ctrl     we wa wd           fl  ev ers          ert          dst ectrl
        vecs[0] = '{1, 3, 4, 5, 32'h11,      32'h22,      32'h100,      10'h021, 0, 0, 32'h0,       0,  1, 32'h11,      32'h22,      5,  10'h021};
        vecs[1] = '{1, 3, 4, 5, 32'h11,      32'h22,      32'h4,        10'h021, 1, 3, 32'hDEAD,    0,  1, 32'hDEAD,    32'h22,      5,  10'h021};
        vecs[2] = '{1, 7, 0, 9, 32'h77,      32'h55,      32'hFFFFFFF0, 10'h011, 0, 0, 32'h0,       0,  1, 32'h77,      32'h0,       0,  10'h011};
        vecs[3] = '{1, 0, 6, 2, 32'h99,      32'h66,      32'h0,        10'h021, 1, 0, 32'hBEEF,    0,  1, 32'h0,       32'h66,      2,  10'h021};
        vecs[4] = '{1, 10, 11, 3, 32'h1010,  32'h1111,    32'h7,        10'h1C1, 0, 10, 32'hAAAA,   0,  1, 32'h1010,    32'h1111,    11, 10'h1C1};
        vecs[5] = '{1, 12, 12, 13, 32'h1,    32'h2,       32'h8,        10'h3E1, 1, 12, 32'hC0DE,   0,  1, 32'hC0DE,    32'hC0DE,    13, 10'h3E1};
        vecs[6] = '{0, 1, 2, 3, 32'h5,       32'h6,       32'h7,        10'h021, 0, 0, 32'h0,       0,  0, 32'h0,       32'h0,       0,  10'h000};
        vecs[7] = '{1, 1, 2, 3, 32'h5,       32'h6,       32'h7,        10'h021, 1, 1, 32'h9,       1,  0, 32'h0,       32'h0,       0,  10'h000};
        vecs[8] = '{1, 1, 2, 3, 32'hA,       32'hB,       32'h10,       10'h014, 0, 0, 32'h0,       0,  1, 32'hA,       32'hB,       2,  10'h014};
        vecs[9] = '{1, 4, 6, 7, 32'h44,      32'h66,      32'h0,        10'h021, 1, 5, 32'hFF,      0,  1, 32'h44,      32'h66,      7,  10'h021};

        // lw r8, 4(r1): MemRead|MemToReg|ALUSrc|RegWrite, dst = rt = 8
        lw  = '{1, 1, 8, 0, 32'h100, 32'h200, 32'h4, 10'h01B, 0, 0, 32'h0, 0,
                1, 32'h100, 32'h200, 8, 10'h01B};
        // add r10, r8, r9 depending on the load
        dep = '{1, 8, 9, 10, 32'h300, 32'h400, 32'h0, 10'h021, 0, 0, 32'h0, 0,
                1, 32'h300, 32'h400, 10, 10'h021};

        // Reset state
        reset = 1'b0;
        drive(vecs[0]);
        #2;
        check_all_zero("reset_init");
        tick();
        check("reset_hold.ex_valid", 32'(ex_valid), 0);
        reset = 1'b1;

        // Load something, then pulse reset between edges with nonzero inputs.
        drive(vecs[0]);
        tick();
        check("pre_reset.ex_valid", 32'(ex_valid), 1);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        reset = 1'b1;

        // Table of single-cycle captures, bubbles and bypass cases.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            check($sformatf("vec%0d.stall", i), 32'(stall), 0);
            push_exp(vecs[i], vecs[i].ev);
            tick();
            pop_cmp($sformatf("vec%0d", i));
        end

        // Load-use: one bubble, then the held instruction is captured.
        drive(lw);
        push_exp(lw, 1'b1);
        tick();
        pop_cmp("lu_load");
        drive(dep);
        check("lu.stall_hi", 32'(stall), 1);
        exp_cnt++;
        push_exp(dep, 1'b0);
        tick();
        pop_cmp("lu_bubble");
        check("lu.stall_lo", 32'(stall), 0);
        push_exp(dep, 1'b1);
        tick();
        pop_cmp("lu_capture");

        // Flush together with a load-use hazard: bubble wins, stall still counted.
        drive(lw);
        push_exp(lw, 1'b1);
        tick();
        pop_cmp("fl_load");
        dep.fl = 1'b1;
        drive(dep);
        check("fl.stall_hi", 32'(stall), 1);
        exp_cnt++;
        push_exp(dep, 1'b0);
        tick();
        pop_cmp("fl_bubble");
        dep.fl = 1'b0;

        // Saturation from a preloaded count.
        drive(lw);
        push_exp(lw, 1'b1);
        tick();
        pop_cmp("sat_load0");
        force dut.stall_count_q = 32'hFFFF_FFFE;
        #1 release dut.stall_count_q;
        exp_cnt = 32'hFFFF_FFFE;
        drive(dep);
        check("sat0.stall_hi", 32'(stall), 1);
        exp_cnt = 32'hFFFF_FFFF;
        push_exp(dep, 1'b0);
        tick();
        pop_cmp("sat_stall0");
        drive(lw);
        push_exp(lw, 1'b1);
        tick();
        pop_cmp("sat_load1");
        drive(dep);
        check("sat1.stall_hi", 32'(stall), 1);
        push_exp(dep, 1'b0);
        tick();
        pop_cmp("sat_stall1");

        // Reset in the middle of a stall.
        drive(lw);
        exp_cnt = 32'hFFFF_FFFF;
        push_exp(lw, 1'b1);
        tick();
        pop_cmp("rst_load");
        drive(dep);
        check("rst.stall_hi", 32'(stall), 1);
        #2 reset = 1'b0;
        #1 check_all_zero("mid_stall_reset");
        reset = 1'b1;
        exp_cnt = 0;
        push_exp(dep, 1'b1);
        tick();
        pop_cmp("post_reset_capture");

        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
